fifo_wptr_full: RTL and testbench

- Write-side pointer and full-flag stage of async_fifo, in the write clock domain.
- Keeps the binary write pointer and drives the RAM write address.
- Registers the Gray-coded write pointer for the crossing to the read domain, using bin2gray on the next-pointer value.
- Compares the next write pointer against the read pointer, already synchronised into this domain, to produce a registered full flag.

---
 rtl/fifo_wptr_full.sv | 114 +++++++++++
 tb/tb_fifo_wptr_full.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag stage of the async FIFO (write clock domain).
// Optional almost-full output is enabled by defining FIFO_ALMOST_FULL_EN.

module bin2gray #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

module fifo_wptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_in,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync_in,
  output logic                  wr_accept_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [ADDR_WIDTH:0]   wptr_gray_out,
  output logic                  full_out,
`ifdef FIFO_ALMOST_FULL_EN
  output logic                  almost_full_out,
`endif
  output logic                  overflow_out
);

  localparam int PW = ADDR_WIDTH + 1;

  if (ADDR_WIDTH < 1 || AF_MARGIN < 1 || AF_MARGIN > (2**ADDR_WIDTH) - 1) begin : g_param_illegal
    $error("fifo_wptr_full: illegal ADDR_WIDTH/AF_MARGIN");
  end

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic          r_full;
  logic          r_overflow;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_full_target;

  assign wr_accept_out = wr_en_in & ~r_full;
  assign w_wbin_next   = r_wbin + {{ADDR_WIDTH{1'b0}}, wr_accept_out};

  bin2gray #(
    .WIDTH(PW)
  ) u_bin2gray (
    .i_bin (w_wbin_next),
    .o_gray(w_wgray_next)
  );

  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray code that means the top two bits differ and the rest match.
  if (ADDR_WIDTH == 1) begin : g_full_aw1
    assign w_full_target = ~rptr_gray_sync_in;
  end else begin : g_full_awn
    assign w_full_target = {~rptr_gray_sync_in[ADDR_WIDTH:ADDR_WIDTH-1],
                            rptr_gray_sync_in[ADDR_WIDTH-2:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin     <= '0;
      r_wgray    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wbin     <= w_wbin_next;
      r_wgray    <= w_wgray_next;
      r_full     <= (w_wgray_next == w_full_target);
      r_overflow <= wr_en_in & r_full;
    end
  end

  assign wr_addr_out   = r_wbin[ADDR_WIDTH-1:0];
  assign wptr_gray_out = r_wgray;
  assign full_out      = r_full;
  assign overflow_out  = r_overflow;

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [PW-1:0] LP_AF_THRESH = PW'((2**ADDR_WIDTH) - AF_MARGIN);

  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_occupancy;
  logic          r_almost_full;

  always_comb begin
    w_rbin         = '0;
    w_rbin[PW-1]   = rptr_gray_sync_in[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      w_rbin[i] = w_rbin[i+1] ^ rptr_gray_sync_in[i];
    end
  end

  // Modulo subtraction gives the true occupancy even across pointer wrap.
  assign w_occupancy = w_wbin_next - w_rbin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_occupancy >= LP_AF_THRESH);
    end
  end

  assign almost_full_out = r_almost_full;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full (ADDR_WIDTH=2, AF_MARGIN=1).
// Almost-full checks are compiled in when FIFO_ALMOST_FULL_EN is defined.

module tb_fifo_wptr_full;

  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          wr_en_in;
  logic [AW:0]   rptr_gray_sync_in;
  logic          wr_accept_out;
  logic [AW-1:0] wr_addr_out;
  logic [AW:0]   wptr_gray_out;
  logic          full_out;
  logic          overflow_out;
`ifdef FIFO_ALMOST_FULL_EN
  logic          almost_full_out;
`endif

  int n_total  = 0;
  int n_passed = 0;

  fifo_wptr_full #(
    .ADDR_WIDTH(AW),
    .AF_MARGIN (1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_en_in         (wr_en_in),
    .rptr_gray_sync_in(rptr_gray_sync_in),
    .wr_accept_out    (wr_accept_out),
    .wr_addr_out      (wr_addr_out),
    .wptr_gray_out    (wptr_gray_out),
    .full_out         (full_out),
`ifdef FIFO_ALMOST_FULL_EN
    .almost_full_out  (almost_full_out),
`endif
    .overflow_out     (overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [2:0] rptr;
    logic       exp_accept;
    logic [1:0] exp_addr;
    logic [2:0] exp_gray;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [2:0] to_gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  // Drive inputs mid-cycle, check the combinational accept, then check
  // registered outputs 1 time unit after the next rising edge.
  task automatic step(input vec_t v, input string tag);
    wr_en_in          = v.wr;
    rptr_gray_sync_in = v.rptr;
    #1;
    chk({tag, " accept"}, 32'(wr_accept_out), 32'(v.exp_accept));
    @(posedge clk);
    #1;
    chk({tag, " addr"}, 32'(wr_addr_out),   32'(v.exp_addr));
    chk({tag, " gray"}, 32'(wptr_gray_out), 32'(v.exp_gray));
    chk({tag, " full"}, 32'(full_out),      32'(v.exp_full));
    chk({tag, " ovf"},  32'(overflow_out),  32'(v.exp_ovf));
  endtask

  task automatic do_reset();
    wr_en_in          = 1'b0;
    rptr_gray_sync_in = '0;
    rst_n             = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] prev_gray;
    logic [2:0] rb;
    logic [2:0] wb;

    // fill, overflow, drain release, refill-to-full
    vecs[0] = '{1'b1, 3'b000, 1'b1, 2'd1, 3'b001, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'b000, 1'b1, 2'd2, 3'b011, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 3'b000, 1'b1, 2'd3, 3'b010, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 3'b000, 1'b1, 2'd0, 3'b110, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 3'b001, 1'b1, 2'd1, 3'b111, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 3'b001, 1'b0, 2'd1, 3'b111, 1'b1, 1'b0};

    // reset state before any clock edge
    wr_en_in          = 1'b0;
    rptr_gray_sync_in = '0;
    rst_n             = 1'b0;
    #2;
    chk("rst addr", 32'(wr_addr_out),   32'd0);
    chk("rst gray", 32'(wptr_gray_out), 32'd0);
    chk("rst full", 32'(full_out),      32'd0);
    chk("rst ovf",  32'(overflow_out),  32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) step(vecs[i], $sformatf("vec%0d", i));

    // mid-stream asynchronous reset with pointer at 3
    do_reset();
    for (int i = 0; i < 3; i++) step(vecs[i], $sformatf("pre%0d", i));
    chk("pre-rst addr", 32'(wr_addr_out), 32'd3);
    wr_en_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst addr", 32'(wr_addr_out),   32'd0);
    chk("async rst gray", 32'(wptr_gray_out), 32'd0);
    chk("async rst full", 32'(full_out),      32'd0);
    chk("async rst ovf",  32'(overflow_out),  32'd0);
    @(posedge clk);
    #1;
    chk("held rst addr", 32'(wr_addr_out), 32'd0);
    rst_n = 1'b1;
    chk("post-rst addr", 32'(wr_addr_out), 32'd0);
    step('{1'b1, 3'b000, 1'b1, 2'd1, 3'b001, 1'b0, 1'b0}, "post-rst wr");

    // wrap: read pointer trails two entries behind
    do_reset();
    prev_gray = 3'b000;
    for (int k = 0; k < 10; k++) begin
      rb = (k >= 2) ? 3'(k - 2) : 3'd0;
      wb = 3'(k + 1);
      step('{1'b1, to_gray(rb), 1'b1, wb[1:0], to_gray(wb), 1'b0, 1'b0}, $sformatf("wrap%0d", k));
      chk($sformatf("wrap%0d onebit", k), 32'($countones(wptr_gray_out ^ prev_gray)), 32'd1);
      prev_gray = wptr_gray_out;
    end

`ifdef FIFO_ALMOST_FULL_EN
    do_reset();
    chk("af rst", 32'(almost_full_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(vecs[i], $sformatf("af-fill%0d", i));
      chk($sformatf("af after %0d", i + 1), 32'(almost_full_out), (i >= 2) ? 32'd1 : 32'd0);
    end
    step('{1'b0, 3'b011, 1'b0, 2'd0, 3'b110, 1'b0, 1'b0}, "af drain");
    chk("af drain af", 32'(almost_full_out), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
